psd_result_buffer: RTL and testbench

- Downstream of the PSD stage. Captures the four 36-bit averaged lock-in results (A_X, A_Y, B_X, B_Y) on each averaging-done flag.
- Stores captured results as tagged frames in a small frame FIFO.
- Serves the frames to the ARM as a stream of 16-bit words through a one-word-per-strobe read handshake.
- Decouples the 1 MHz PSD output rate from irregular ARM polling. Overruns are reported rather than silently lost.

---
 rtl/psd_pkg.sv | 49 ++++
 rtl/psd_frame_fifo.sv | 59 +++++
 rtl/psd_result_buffer.sv | 98 +++++++++
 tb/tb_psd_result_buffer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psd_pkg.sv
// Shared constants, frame layout and word-select helper for the PSD result buffer.
package psd_pkg;

  localparam int FRAME_WORDS = 13;
  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam int SEQ_W = 12;
  localparam int RES_W = 36;
  localparam int FRAME_W = 4 * RES_W + SEQ_W;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [RES_W-1:0] a_x;
    logic [RES_W-1:0] a_y;
    logic [RES_W-1:0] b_x;
    logic [RES_W-1:0] b_y;
  } frame_t;

  // part 0 is the sign-extended top nibble, part 1 bits [31:16], part 2 bits [15:0]
  function automatic logic [15:0] res_word(input logic [RES_W-1:0] v, input logic [1:0] part);
    logic [15:0] w;
    case (part)
      2'd0:    w = {{12{v[35]}}, v[35:32]};
      2'd1:    w = v[31:16];
      default: w = v[15:0];
    endcase
    return w;
  endfunction

  function automatic logic [15:0] frame_word(input frame_t f, input logic [3:0] k);
    logic [15:0] w;
    case (k)
      4'd0:    w = {HDR_TAG, f.seq};
      4'd1:    w = res_word(f.a_x, 2'd0);
      4'd2:    w = res_word(f.a_x, 2'd1);
      4'd3:    w = res_word(f.a_x, 2'd2);
      4'd4:    w = res_word(f.a_y, 2'd0);
      4'd5:    w = res_word(f.a_y, 2'd1);
      4'd6:    w = res_word(f.a_y, 2'd2);
      4'd7:    w = res_word(f.b_x, 2'd0);
      4'd8:    w = res_word(f.b_x, 2'd1);
      4'd9:    w = res_word(f.b_x, 2'd2);
      4'd10:   w = res_word(f.b_y, 2'd0);
      4'd11:   w = res_word(f.b_y, 2'd1);
      default: w = res_word(f.b_y, 2'd2);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/psd_frame_fifo.sv
// Frame FIFO: DEPTH slots of one full result frame, registered count/full/empty.
module psd_frame_fifo
  import psd_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               i_clk_1M,
  input  logic               i_rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [FRAME_W-1:0] wr_frame,
  input  logic               pop,
  output logic [FRAME_W-1:0] head,
  output logic [DEPTH_W:0]   count,
  output logic               full,
  output logic               empty
);

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W:0]   count_nxt;

  assign head = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (wr_en && !pop)
      count_nxt = count + 1'b1;
    else if (!wr_en && pop)
      count_nxt = count - 1'b1;
  end

  // Storage needs no reset; only pointers and count define what is valid.
  always_ff @(posedge i_clk_1M) begin
    if (wr_en && !i_rst && !clr)
      mem[wr_ptr] <= wr_frame;
  end

  always_ff @(posedge i_clk_1M) begin
    if (i_rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (DEPTH_W+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/psd_result_buffer.sv
// Captures averaged lock-in results as tagged frames and streams them to the ARM as 16-bit words.
module psd_result_buffer
  import psd_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic               i_clk_1M,
  input  logic               i_rst,
  input  logic [35:0]        i_A_X,
  input  logic [35:0]        i_A_Y,
  input  logic [35:0]        i_B_X,
  input  logic [35:0]        i_B_Y,
  input  logic               i_aver_flag,
  input  logic               i_clr,
  input  logic               i_rd_req,
  output logic [15:0]        o_rd_data,
  output logic               o_rd_valid,
  output logic [DEPTH_W:0]   o_frame_cnt,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_overflow,
  output logic               o_underflow
);

  // Read handshake: each cycle i_rd_req is high while a frame is stored returns one
  // word the following cycle with o_rd_valid high for exactly that cycle; a request
  // while empty returns nothing and sets o_underflow.

  logic               flag_d;
  logic [SEQ_W-1:0]   seq;
  logic [3:0]         word_idx;
  logic               capture;
  logic               rd_ok;
  logic               pop_now;
  logic               wr_en;
  frame_t             wr_frame;
  logic [FRAME_W-1:0] head_bits;
  frame_t             head;

  assign capture  = i_aver_flag && !flag_d;
  assign rd_ok    = i_rd_req && !o_empty && !i_clr && !i_rst;
  assign pop_now  = rd_ok && (word_idx == 4'(FRAME_WORDS - 1));
  // A full FIFO still accepts a capture when the head frame leaves in the same cycle.
  assign wr_en    = capture && !i_clr && !i_rst && (!o_full || pop_now);
  assign wr_frame = '{seq: seq, a_x: i_A_X, a_y: i_A_Y, b_x: i_B_X, b_y: i_B_Y};
  assign head     = frame_t'(head_bits);

  psd_frame_fifo #(
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_fifo (
    .i_clk_1M (i_clk_1M),
    .i_rst    (i_rst),
    .clr      (i_clr),
    .wr_en    (wr_en),
    .wr_frame (wr_frame),
    .pop      (pop_now),
    .head     (head_bits),
    .count    (o_frame_cnt),
    .full     (o_full),
    .empty    (o_empty)
  );

  always_ff @(posedge i_clk_1M) begin
    if (i_rst) begin
      flag_d      <= 1'b0;
      seq         <= '0;
      word_idx    <= '0;
      o_rd_data   <= '0;
      o_rd_valid  <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      flag_d <= i_aver_flag;
      // seq counts capture events, so dropped frames show up as header gaps
      if (capture)
        seq <= seq + 1'b1;
      if (i_clr) begin
        word_idx    <= '0;
        o_rd_valid  <= 1'b0;
        o_overflow  <= 1'b0;
        o_underflow <= 1'b0;
      end else begin
        o_rd_valid <= rd_ok;
        if (rd_ok) begin
          o_rd_data <= frame_word(head, word_idx);
          word_idx  <= pop_now ? 4'd0 : word_idx + 1'b1;
        end
        if (i_rd_req && o_empty)
          o_underflow <= 1'b1;
        if (capture && o_full && !pop_now)
          o_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psd_result_buffer.sv
// Self-checking bench for psd_result_buffer against a queue-based frame model.
module tb_psd_result_buffer;

  localparam int DEPTH   = 8;
  localparam int DEPTH_W = 3;

  logic              i_clk_1M = 1'b0;
  logic              i_rst = 1'b1;
  logic [35:0]       i_A_X = '0, i_A_Y = '0, i_B_X = '0, i_B_Y = '0;
  logic              i_aver_flag = 1'b0;
  logic              i_clr = 1'b0;
  logic              i_rd_req = 1'b0;
  logic [15:0]       o_rd_data;
  logic              o_rd_valid;
  logic [DEPTH_W:0]  o_frame_cnt;
  logic              o_empty, o_full, o_overflow, o_underflow;

  psd_result_buffer #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .i_clk_1M    (i_clk_1M),
    .i_rst       (i_rst),
    .i_A_X       (i_A_X),
    .i_A_Y       (i_A_Y),
    .i_B_X       (i_B_X),
    .i_B_Y       (i_B_Y),
    .i_aver_flag (i_aver_flag),
    .i_clr       (i_clr),
    .i_rd_req    (i_rd_req),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .o_frame_cnt (o_frame_cnt),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  // ---------------- clock ----------------
  always #5 i_clk_1M = ~i_clk_1M;

  // ---------------- reference model ----------------
  typedef struct {
    int          seq;
    logic [35:0] v0, v1, v2, v3;
  } mframe_t;

  mframe_t     mq[$];
  int          m_seq;
  int          m_widx;
  logic        m_prev_flag;
  logic        m_ovf, m_udf, m_valid;
  logic [15:0] m_data;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [35:0] rand36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[35:0];
  endfunction

  // Word k of a frame from the documented layout, via signed arithmetic.
  function automatic logic [15:0] exp_word(input mframe_t f, input int k);
    logic [35:0] v;
    longint      s;
    longint      r;
    if (k == 0) return 16'(32'hA000 | (f.seq & 32'hFFF));
    case ((k - 1) / 3)
      0:       v = f.v0;
      1:       v = f.v1;
      2:       v = f.v2;
      default: v = f.v3;
    endcase
    s = longint'({28'd0, v});
    if (v[35]) s = s - (longint'(1) <<< 36);
    case ((k - 1) % 3)
      0:       r = s >>> 32;
      1:       r = s >>> 16;
      default: r = s;
    endcase
    return 16'(r & 64'hFFFF);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_seq = 0; m_widx = 0; m_prev_flag = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_data = 16'h0;
  endtask

  task automatic model_update(input logic f, input logic r, input logic c);
    logic    cap, was_full, was_empty, popped;
    mframe_t nf;
    cap = f && !m_prev_flag;
    m_prev_flag = f;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    popped = 1'b0;
    if (cap) begin
      nf.seq = m_seq; nf.v0 = i_A_X; nf.v1 = i_A_Y; nf.v2 = i_B_X; nf.v3 = i_B_Y;
      m_seq = (m_seq + 1) % 4096;
    end
    if (c) begin
      mq.delete();
      m_widx = 0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_valid = r && !was_empty;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) begin
        m_data = exp_word(mq[0], m_widx);
        m_widx++;
        if (m_widx == 13) begin
          m_widx = 0;
          void'(mq.pop_front());
          popped = 1'b1;
        end
      end
      if (cap) begin
        if (!was_full || popped) mq.push_back(nf);
        else m_ovf = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic f, input logic r, input logic c);
    i_aver_flag = f; i_rd_req = r; i_clr = c;
    model_update(f, r, c);
    @(posedge i_clk_1M); #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_aver_flag = 1'b0; i_rd_req = 1'b0; i_clr = 1'b0;
    @(posedge i_clk_1M); #1;
    @(posedge i_clk_1M); #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic rand_inputs();
    i_A_X = rand36(); i_A_Y = rand36(); i_B_X = rand36(); i_B_Y = rand36();
  endtask

  task automatic pulse_capture();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1; i_rd_req = 1'b1; i_aver_flag = 1'b0; i_clr = 1'b0;
    rand_inputs();
    repeat (3) begin @(posedge i_clk_1M); #1; end
    i_rst = 1'b0; i_rd_req = 1'b0;
    model_reset();
    n_checks++; if (o_rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", o_rd_valid); end
    n_checks++; if (o_rd_data !== 16'h0) begin n_errors++; $display("FAIL reset_data got=%h exp=0000", o_rd_data); end
    n_checks++; if (o_frame_cnt !== 4'd0) begin n_errors++; $display("FAIL reset_cnt got=%0d exp=0", o_frame_cnt); end
    n_checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin n_errors++; $display("FAIL reset_empty_full got=%b%b exp=10", o_empty, o_full); end
    n_checks++; if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin n_errors++; $display("FAIL reset_sticky got=%b%b exp=00", o_overflow, o_underflow); end
  endtask

  task automatic test_capture_read();
    logic [15:0] exp_tab [13];
    exp_tab = '{16'hA000, 16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                16'hFFF8, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 16'h0000};
    do_reset();
    i_A_X = 36'h000000001; i_A_Y = 36'hFFFFFFFFF; i_B_X = 36'h812345678; i_B_Y = 36'h0;
    step(1'b1, 1'b0, 1'b0);
    n_checks++; if (o_frame_cnt !== 4'd1 || o_empty !== 1'b0) begin n_errors++; $display("FAIL capture_visible cnt=%0d empty=%b exp cnt=1 empty=0", o_frame_cnt, o_empty); end
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) begin
      step(1'b0, 1'b1, 1'b0);
      n_checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp_tab[k]) begin n_errors++; $display("FAIL capture_word%0d got v=%b d=%h exp v=1 d=%h", k, o_rd_valid, o_rd_data, exp_tab[k]); end
    end
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (o_empty !== 1'b1 || o_frame_cnt !== 4'd0) begin n_errors++; $display("FAIL capture_drained empty=%b cnt=%0d exp 1/0", o_empty, o_frame_cnt); end
    n_checks++; if (o_rd_valid !== 1'b0) begin n_errors++; $display("FAIL capture_valid_drop got=%b exp=0", o_rd_valid); end
  endtask

  task automatic test_level_flag();
    rand_inputs();
    repeat (20) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (o_frame_cnt !== 4'd1) begin n_errors++; $display("FAIL level_cnt got=%0d exp=1", o_frame_cnt); end
    step(1'b0, 1'b1, 1'b0);
    n_checks++; if (o_rd_data !== 16'hA001) begin n_errors++; $display("FAIL level_hdr got=%h exp=a001", o_rd_data); end
    repeat (12) step(1'b0, 1'b1, 1'b0);
    n_checks++; if (o_rd_data !== m_data || o_empty !== 1'b1) begin n_errors++; $display("FAIL level_tail got=%h empty=%b exp=%h empty=1", o_rd_data, o_empty, m_data); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin rand_inputs(); pulse_capture(); end
    n_checks++; if (o_full !== 1'b1 || o_overflow !== 1'b1 || o_frame_cnt !== 4'd8) begin n_errors++; $display("FAIL ovf_state full=%b ovf=%b cnt=%0d exp 1/1/8", o_full, o_overflow, o_frame_cnt); end
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 13; k++) begin
        step(1'b0, 1'b1, 1'b0);
        if (k == 0) begin
          n_checks++; if (o_rd_data !== 16'(16'hA000 + f)) begin n_errors++; $display("FAIL ovf_hdr%0d got=%h exp=%h", f, o_rd_data, 16'(16'hA000 + f)); end
        end else begin
          n_checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== m_data) begin n_errors++; $display("FAIL ovf_f%0d_w%0d got=%h exp=%h", f, k, o_rd_data, m_data); end
        end
      end
    end
    n_checks++; if (o_empty !== 1'b1 || o_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_after_drain empty=%b ovf=%b exp 1/1", o_empty, o_overflow); end
    rand_inputs(); pulse_capture();
    step(1'b0, 1'b1, 1'b0);
    n_checks++; if (o_rd_data !== 16'hA00A) begin n_errors++; $display("FAIL ovf_gap_hdr got=%h exp=a00a", o_rd_data); end
    repeat (12) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_simul_capture_pop();
    do_reset();
    for (int i = 0; i < 8; i++) begin rand_inputs(); pulse_capture(); end
    repeat (12) step(1'b0, 1'b1, 1'b0);
    rand_inputs();
    step(1'b1, 1'b1, 1'b0);
    n_checks++; if (o_frame_cnt !== 4'd8 || o_full !== 1'b1 || o_overflow !== 1'b0) begin n_errors++; $display("FAIL simul_state cnt=%0d full=%b ovf=%b exp 8/1/0", o_frame_cnt, o_full, o_overflow); end
    n_checks++; if (o_rd_data !== m_data) begin n_errors++; $display("FAIL simul_w12 got=%h exp=%h", o_rd_data, m_data); end
    step(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 8 * 13; n++) begin
      step(1'b0, 1'b1, 1'b0);
      n_checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== m_data) begin n_errors++; $display("FAIL simul_drain%0d got=%h exp=%h", n, o_rd_data, m_data); end
    end
    n_checks++; if (o_empty !== 1'b1 || mq.size() != 0) begin n_errors++; $display("FAIL simul_empty got=%b exp=1", o_empty); end
  endtask

  task automatic test_underflow();
    logic [15:0] held;
    held = o_rd_data;
    step(1'b0, 1'b1, 1'b0);
    n_checks++; if (o_rd_valid !== 1'b0 || o_underflow !== 1'b1) begin n_errors++; $display("FAIL udf_set valid=%b udf=%b exp 0/1", o_rd_valid, o_underflow); end
    n_checks++; if (o_rd_data !== held) begin n_errors++; $display("FAIL udf_hold got=%h exp=%h", o_rd_data, held); end
    step(1'b0, 1'b0, 1'b1);
    n_checks++; if (o_underflow !== 1'b0) begin n_errors++; $display("FAIL udf_clr got=%b exp=0", o_underflow); end
  endtask

  task automatic test_mid_frame_abort();
    int s;
    step(1'b0, 1'b0, 1'b1);
    s = m_seq;
    rand_inputs(); pulse_capture();
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_checks++; if (o_frame_cnt !== 4'd0 || o_empty !== 1'b1 || o_rd_valid !== 1'b0) begin n_errors++; $display("FAIL abort_clr cnt=%0d empty=%b valid=%b exp 0/1/0", o_frame_cnt, o_empty, o_rd_valid); end
    rand_inputs(); pulse_capture();
    step(1'b0, 1'b1, 1'b0);
    n_checks++; if (o_rd_data !== 16'(32'hA000 | ((s + 1) % 4096))) begin n_errors++; $display("FAIL abort_hdr got=%h exp=%h", o_rd_data, 16'(32'hA000 | ((s + 1) % 4096))); end
    repeat (12) begin
      step(1'b0, 1'b1, 1'b0);
      n_checks++; if (o_rd_data !== m_data) begin n_errors++; $display("FAIL abort_word got=%h exp=%h", o_rd_data, m_data); end
    end
  endtask

  task automatic test_random();
    logic f, r, c;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      c = ($urandom_range(0, 199) == 0);
      f = c ? 1'b0 : ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 99) < (n < 1500 ? 30 : 80));
      step(f, r, c);
      n_checks++;
      if (o_rd_valid !== m_valid || o_rd_data !== m_data || o_frame_cnt !== 4'(mq.size()) ||
          o_empty !== (mq.size() == 0) || o_full !== (mq.size() == DEPTH) ||
          o_overflow !== m_ovf || o_underflow !== m_udf) begin
        n_errors++;
        $display("FAIL random_cyc%0d got v=%b d=%h cnt=%0d e=%b f=%b ovf=%b udf=%b exp v=%b d=%h cnt=%0d ovf=%b udf=%b",
                 n, o_rd_valid, o_rd_data, o_frame_cnt, o_empty, o_full, o_overflow, o_underflow,
                 m_valid, m_data, mq.size(), m_ovf, m_udf);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_capture_read();
    test_level_flag();
    test_overflow();
    test_simul_capture_pop();
    test_underflow();
    test_mid_frame_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
